// File: rtl/serv_bus_arbiter_if.sv
// Bus bundle between N classic-cycle requesters, the arbiter and one memory port.
// Channel k of each packed per-channel vector occupies slice k of that vector.
interface serv_bus_arbiter_if #(
  parameter int N  = 2,
  parameter int GW = (N > 1) ? $clog2(N) : 1
);
  logic [N*32-1:0] i_m_adr;
  logic [N*32-1:0] i_m_dat;
  logic [N*4-1:0]  i_m_sel;
  logic [N-1:0]    i_m_we;
  logic [N-1:0]    i_m_cyc;
  logic [31:0]     o_m_rdt;
  logic [N-1:0]    o_m_ack;
  logic [N-1:0]    o_m_err;
  logic [31:0]     o_s_adr;
  logic [31:0]     o_s_dat;
  logic [3:0]      o_s_sel;
  logic            o_s_we;
  logic            o_s_cyc;
  logic [31:0]     i_s_rdt;
  logic            i_s_ack;
  logic [GW-1:0]   o_grant;
  logic            o_busy;

  // Arbiter side
  modport slave (
    input  i_m_adr, i_m_dat, i_m_sel, i_m_we, i_m_cyc, i_s_rdt, i_s_ack,
    output o_m_rdt, o_m_ack, o_m_err, o_s_adr, o_s_dat, o_s_sel, o_s_we,
    output o_s_cyc, o_grant, o_busy
  );

  // Requester/memory side
  modport master (
    output i_m_adr, i_m_dat, i_m_sel, i_m_we, i_m_cyc, i_s_rdt, i_s_ack,
    input  o_m_rdt, o_m_ack, o_m_err, o_s_adr, o_s_dat, o_s_sel, o_s_we,
    input  o_s_cyc, o_grant, o_busy
  );
endinterface

// File: rtl/serv_bus_arbiter.sv
// N-channel arbiter merging serv ibus/dbus classic cycles onto one memory port,
// with round-robin or fixed priority and an optional ack timeout.
module serv_bus_arbiter #(
  parameter int    N       = 2,
  parameter string ARB     = "RR",
  parameter int    TIMEOUT = 0,
  parameter int    GW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  serv_bus_arbiter_if.slave bus
);

  localparam bit            FIXED    = (ARB == "FIXED");
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [GW-1:0]        grant, grant_nxt;
  logic [GW-1:0]        last, last_nxt;
  logic [GW-1:0]        win;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [N-1:0][31:0]   adr_v, dat_v;
  logic [N-1:0][3:0]    sel_v;
  logic                 req_g, ack_ok, abort, expire;
  logic                 found;
  int                   idx;

  assign adr_v = bus.i_m_adr;
  assign dat_v = bus.i_m_dat;
  assign sel_v = bus.i_m_sel;

  // Winner search: FIXED scans from 0, RR scans from the channel after the last one served.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      if (FIXED) idx = k;
      else       idx = (int'(last) + 1 + k) % N;
      if (!found && bus.i_m_cyc[idx[GW-1:0]]) begin
        win   = idx[GW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    req_g  = bus.i_m_cyc[grant];
    ack_ok = (state == BUSY) && req_g && bus.i_s_ack;
    abort  = (state == BUSY) && !req_g;
    expire = (TIMEOUT > 0) && (state == BUSY) && req_g && !bus.i_s_ack && (cnt == CNT_LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      grant <= '0;
      last  <= GW'(N - 1);
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (|bus.i_m_cyc) begin
          state_nxt = BUSY;
          grant_nxt = win;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (ack_ok || abort || expire) begin
          state_nxt = IDLE;
          last_nxt  = grant;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory side is a pure mux of the granted channel; the timeout cycle masks cyc and rdt.
  always_comb begin
    bus.o_s_adr = adr_v[grant];
    bus.o_s_dat = dat_v[grant];
    bus.o_s_sel = sel_v[grant];
    bus.o_s_we  = bus.i_m_we[grant];
    bus.o_s_cyc = (state == BUSY) && req_g && !expire;
    bus.o_m_rdt = expire ? 32'h0 : bus.i_s_rdt;
    bus.o_m_ack = '0;
    bus.o_m_err = '0;
    if (ack_ok || expire) bus.o_m_ack[grant] = 1'b1;
    if (expire)           bus.o_m_err[grant] = 1'b1;
    bus.o_grant = grant;
    bus.o_busy  = (state == BUSY);
  end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Directed bench for serv_bus_arbiter: round-robin, fixed priority and timeout
// instances, each driven through its own interface.
module tb_serv_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  serv_bus_arbiter_if #(.N(4)) b_rr ();
  serv_bus_arbiter_if #(.N(4)) b_fx ();
  serv_bus_arbiter_if #(.N(4)) b_to ();

  serv_bus_arbiter #(.N(4), .ARB("RR"), .TIMEOUT(0)) u_rr (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b_rr));
  serv_bus_arbiter #(.N(4), .ARB("FIXED"), .TIMEOUT(0)) u_fx (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b_fx));
  serv_bus_arbiter #(.N(4), .ARB("RR"), .TIMEOUT(8)) u_to (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b_to));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b_rr.i_m_adr = '0; b_rr.i_m_dat = '0; b_rr.i_m_sel = '0; b_rr.i_m_we = '0;
    b_rr.i_m_cyc = '0; b_rr.i_s_rdt = '0; b_rr.i_s_ack = 1'b0;
    b_fx.i_m_adr = '0; b_fx.i_m_dat = '0; b_fx.i_m_sel = '0; b_fx.i_m_we = '0;
    b_fx.i_m_cyc = '0; b_fx.i_s_rdt = '0; b_fx.i_s_ack = 1'b0;
    b_to.i_m_adr = '0; b_to.i_m_dat = '0; b_to.i_m_sel = '0; b_to.i_m_we = '0;
    b_to.i_m_cyc = '0; b_to.i_s_rdt = '0; b_to.i_s_ack = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_busy",  b_rr.o_busy, 0);
    chk("rst_scyc",  b_rr.o_s_cyc, 0);
    chk("rst_ack",   b_rr.o_m_ack, 0);
    chk("rst_err",   b_to.o_m_err, 0);
    chk("rst_grant", b_rr.o_grant, 0);
    rst_n = 1'b1;

    // Single read on channel 0, memory acks on the third BUSY cycle
    b_rr.i_m_adr[31:0] = 32'h100;
    b_rr.i_m_cyc = 4'b0001;
    #1 chk("t1_cyc_lat", b_rr.o_s_cyc, 0);
    tick();
    chk("t1_cyc_up", b_rr.o_s_cyc, 1);
    chk("t1_adr",    b_rr.o_s_adr, 32'h100);
    chk("t1_busy",   b_rr.o_busy, 1);
    chk("t1_noack",  b_rr.o_m_ack, 0);
    tick();
    chk("t1_wait",   b_rr.o_m_ack, 0);
    tick();
    b_rr.i_s_ack = 1'b1; b_rr.i_s_rdt = 32'hDEADBEEF;
    #1;
    chk("t1_ack", b_rr.o_m_ack, 4'b0001);
    chk("t1_rdt", b_rr.o_m_rdt, 32'hDEADBEEF);
    tick();
    b_rr.i_s_ack = 1'b0; b_rr.i_m_cyc = 4'b0000;
    #1;
    chk("t1_ack_once", b_rr.o_m_ack, 0);
    chk("t1_idle",     b_rr.o_busy, 0);

    // Round-robin fairness from a fresh reset
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    b_rr.i_m_cyc = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      b_rr.i_m_cyc = 4'b1111;
      #1;
      chk("rr_grant", b_rr.o_grant, i % 4);
      chk("rr_scyc",  b_rr.o_s_cyc, 1);
      b_rr.i_s_ack = 1'b1;
      #1;
      chk("rr_ack", b_rr.o_m_ack, 4'b0001 << (i % 4));
      tick();
      b_rr.i_s_ack = 1'b0;
      b_rr.i_m_cyc[i % 4] = 1'b0;
      #1;
      chk("rr_gap", b_rr.o_m_ack, 0);
      chk("rr_dead", b_rr.o_busy, 0);
    end
    b_rr.i_m_cyc = 4'b0000;
    tick();

    // Fixed priority: channel 1 keeps winning over channel 3
    b_fx.i_m_sel = 16'h8421;
    b_fx.i_m_dat[63:32]  = 32'h0000_0011;
    b_fx.i_m_dat[127:96] = 32'hA5A5_0003;
    b_fx.i_m_we = 4'b1000;
    b_fx.i_m_cyc = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fx_grant1", b_fx.o_grant, 1);
      chk("fx_sel1",   b_fx.o_s_sel, 4'h2);
      chk("fx_we1",    b_fx.o_s_we, 0);
      b_fx.i_s_ack = 1'b1;
      #1 chk("fx_ack1", b_fx.o_m_ack, 4'b0010);
      tick();
      b_fx.i_s_ack = 1'b0;
    end
    b_fx.i_m_cyc = 4'b1000;
    tick();
    chk("fx_grant3", b_fx.o_grant, 3);
    chk("fx_sel3",   b_fx.o_s_sel, 4'h8);
    chk("fx_we3",    b_fx.o_s_we, 1);
    chk("fx_dat3",   b_fx.o_s_dat, 32'hA5A5_0003);
    b_fx.i_s_ack = 1'b1;
    #1 chk("fx_ack3", b_fx.o_m_ack, 4'b1000);
    tick();
    b_fx.i_s_ack = 1'b0; b_fx.i_m_cyc = 4'b0000;

    // Timeout with no ack: error on the eighth BUSY cycle
    b_to.i_s_rdt = 32'h1234_5678;
    b_to.i_m_cyc = 4'b0001;
    tick();
    for (int c = 1; c < 8; c++) begin
      chk("to_noerr", b_to.o_m_err, 0);
      chk("to_scyc",  b_to.o_s_cyc, 1);
      tick();
    end
    chk("to_err",  b_to.o_m_err, 4'b0001);
    chk("to_ack",  b_to.o_m_ack, 4'b0001);
    chk("to_rdt0", b_to.o_m_rdt, 0);
    chk("to_cyc0", b_to.o_s_cyc, 0);
    tick();
    b_to.i_m_cyc = 4'b0000;
    #1;
    chk("to_idle",    b_to.o_busy, 0);
    chk("to_err_one", b_to.o_m_err, 0);

    // Ack on the eighth BUSY cycle beats the timeout
    b_to.i_m_cyc = 4'b0100;
    tick();
    chk("ta_grant", b_to.o_grant, 2);
    for (int c = 1; c < 8; c++) tick();
    b_to.i_s_ack = 1'b1; b_to.i_s_rdt = 32'hCAFE_F00D;
    #1;
    chk("ta_ack", b_to.o_m_ack, 4'b0100);
    chk("ta_err", b_to.o_m_err, 0);
    chk("ta_rdt", b_to.o_m_rdt, 32'hCAFE_F00D);
    tick();
    b_to.i_s_ack = 1'b0; b_to.i_m_cyc = 4'b0000;
    #1 chk("ta_idle", b_to.o_busy, 0);

    // Abort: granted channel drops cyc while waiting
    b_rr.i_m_cyc = 4'b0010;
    tick();
    chk("ab_grant", b_rr.o_grant, 1);
    tick();
    b_rr.i_m_cyc = 4'b0000;
    #1;
    chk("ab_cyc0",  b_rr.o_s_cyc, 0);
    chk("ab_noack", b_rr.o_m_ack, 0);
    chk("ab_busy",  b_rr.o_busy, 1);
    tick();
    chk("ab_idle",  b_rr.o_busy, 0);
    chk("ab_grant_hold", b_rr.o_grant, 1);
    b_rr.i_s_ack = 1'b1;
    #1 chk("idle_ack_ignored", b_rr.o_m_ack, 0);
    b_rr.i_s_ack = 1'b0;

    // Reset mid-BUSY, then round-robin restarts at channel 0
    b_rr.i_m_cyc = 4'b1000;
    tick();
    chk("rs_grant3", b_rr.o_grant, 3);
    chk("rs_cyc1",   b_rr.o_s_cyc, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_cyc0",   b_rr.o_s_cyc, 0);
    chk("rs_busy0",  b_rr.o_busy, 0);
    chk("rs_noack",  b_rr.o_m_ack, 0);
    tick();
    b_rr.i_m_cyc = 4'b1111;
    rst_n = 1'b1;
    tick();
    chk("rs_grant0", b_rr.o_grant, 0);
    chk("rs_busy1",  b_rr.o_busy, 1);
    b_rr.i_m_cyc = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
